// File: rtl/macn_accum.sv
// Multi-lane signed multiply-accumulate with grouped results: capture -> multiply ->
// registered adder tree -> accumulate, all stages stalled together by one advance.
module macn_accum #(
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int ACCW  = 32,
  parameter int SAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [LANES*DW-1:0]   a_flat,
  input  logic [LANES*DW-1:0]   b_flat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACCW-1:0]       out_data,
  output logic                  out_sat
);
  localparam int  LVLS   = $clog2(LANES);
  localparam int  PW     = 2 * DW;
  localparam int  TW     = PW + LVLS;
  localparam int  AW     = ACCW + 1;
  localparam bit  SAT_EN = (SAT != 0);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Input capture stage
  logic [LANES*DW-1:0] a_reg, b_reg;
  logic c_valid_reg, c_first_reg, c_last_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_valid_reg <= 1'b0;
      c_first_reg <= 1'b0;
      c_last_reg  <= 1'b0;
    end else if (adv) begin
      c_valid_reg <= in_valid;
      c_first_reg <= in_first;
      c_last_reg  <= in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      a_reg <= a_flat;
      b_reg <= b_flat;
    end
  end

  // Multiply stage
  logic signed [PW-1:0] prod_reg [LANES];
  logic m_valid_reg, m_first_reg, m_last_reg;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_mul
      always_ff @(posedge clk) begin
        if (adv)
          prod_reg[gi] <= PW'($signed(a_reg[gi*DW +: DW])) * PW'($signed(b_reg[gi*DW +: DW]));
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_reg <= 1'b0;
      m_first_reg <= 1'b0;
      m_last_reg  <= 1'b0;
    end else if (adv) begin
      m_valid_reg <= c_valid_reg;
      m_first_reg <= c_first_reg;
      m_last_reg  <= c_last_reg;
    end
  end

  // Adder tree stored heap-style: node k sums children 2k and 2k+1, indices >= LANES
  // are the products, so node 1 (the root) emerges after LVLS registered levels.
  logic signed [TW-1:0] tree_reg [1:LANES-1];

  generate
    for (gi = 1; gi < LANES; gi++) begin : g_node
      if (2 * gi >= LANES) begin : g_leaf
        always_ff @(posedge clk) begin
          if (adv)
            tree_reg[gi] <= TW'(prod_reg[2*gi-LANES]) + TW'(prod_reg[2*gi-LANES+1]);
        end
      end else begin : g_inner
        always_ff @(posedge clk) begin
          if (adv)
            tree_reg[gi] <= tree_reg[2*gi] + tree_reg[2*gi+1];
        end
      end
    end
  endgenerate

  logic [LVLS-1:0] t_valid_reg, t_first_reg, t_last_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      t_valid_reg <= '0;
      t_first_reg <= '0;
      t_last_reg  <= '0;
    end else if (adv) begin
      t_valid_reg[0] <= m_valid_reg;
      t_first_reg[0] <= m_first_reg;
      t_last_reg[0]  <= m_last_reg;
      for (int l = 1; l < LVLS; l++) begin
        t_valid_reg[l] <= t_valid_reg[l-1];
        t_first_reg[l] <= t_first_reg[l-1];
        t_last_reg[l]  <= t_last_reg[l-1];
      end
    end
  end

  // Accumulate stage
  logic fin_valid, fin_first, fin_last;
  assign fin_valid = t_valid_reg[LVLS-1];
  assign fin_first = t_first_reg[LVLS-1];
  assign fin_last  = t_last_reg[LVLS-1];

  logic signed [ACCW-1:0] acc_reg, acc_next;
  logic                   sat_reg, sat_next;
  logic signed [AW-1:0]   sum_ext, base, acc_sum;
  logic                   ovf;

  always_comb begin
    sum_ext  = AW'(tree_reg[1]);
    base     = fin_first ? '0 : AW'(acc_reg);
    acc_sum  = base + sum_ext;
    ovf      = acc_sum[AW-1] != acc_sum[ACCW-1];
    acc_next = acc_sum[ACCW-1:0];
    sat_next = fin_first ? 1'b0 : sat_reg;
    if (SAT_EN && ovf) begin
      acc_next = acc_sum[AW-1] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
      sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg   <= '0;
      sat_reg   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      if (fin_valid) begin
        acc_reg <= acc_next;
        sat_reg <= sat_next;
      end
      out_valid <= fin_valid && fin_last;
      if (fin_valid && fin_last) begin
        out_data <= acc_next;
        out_sat  <= sat_next;
      end
    end
  end

endmodule

// File: doc/macn_accum.md
MACN_ACCUM -- requirements
Module: macn_accum

Interface
REQ-001 SHALL have parameter LANES, default 4, giving multiply lanes per beat; power of two, 2..16.
REQ-002 SHALL have parameter DW, default 8, giving signed operand width.
REQ-003 SHALL have parameter ACCW, default 32, giving signed accumulator/result width; ACCW >= 2*DW+log2(LANES).
REQ-004 SHALL have parameter SAT, default 1; 1 = saturating accumulation, 0 = two's-complement wrap.
REQ-005 clk  in  1  clock; all logic rising-edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_valid  in  1  input beat valid.
REQ-008 in_ready  out  1  block accepts beat this cycle.
REQ-009 in_first  in  1  beat starts an accumulation group.
REQ-010 in_last  in  1  beat ends an accumulation group.
REQ-011 a_flat  in  LANES*DW  signed operands; lane i at [i*DW +: DW].
REQ-012 b_flat  in  LANES*DW  signed operands, same packing.
REQ-013 out_valid  out  1  result valid.
REQ-014 out_ready  in  1  downstream accepts result.
REQ-015 out_data  out  ACCW  signed group result.
REQ-016 out_sat  out  1  group saturated at least once (always 0 when SAT=0).

Function
REQ-017 Beat accepted SHALL mean in_valid && in_ready on a rising edge.
REQ-018 Global stall: adv = !out_valid || out_ready; in_ready SHALL equal adv; every pipeline register (data and valid/first/last tags) SHALL hold when adv=0.
REQ-019 Stage M: 1 register stage of LANES products, each 2*DW bits, full signed.
REQ-020 Stage T: binary adder tree, log2(LANES) registered levels; each level widens by 1 bit, no truncation.
REQ-021 Stage A: tree sum sign-extended to ACCW+1 bits; if beat has first, acc = sum; else acc = acc + sum.
REQ-022 SAT=1: acc result outside ACCW signed range SHALL clamp to 2^(ACCW-1)-1 or -2^(ACCW-1) and set group sticky sat flag; SAT=0: wrap to ACCW bits.
REQ-023 Sticky sat flag SHALL clear on a first beat (then set by that beat if it saturates).
REQ-024 Beat with last SHALL load out_data and out_sat with the post-update acc and flag, set out_valid, in the same edge as the acc update.
REQ-025 Latency, no stall: last beat accepted at edge N -> out_valid=1 after edge N+2+log2(LANES) (4 edges for LANES=4).
REQ-026 out_valid SHALL stay 1 and out_data/out_sat stable until out_ready=1; out_valid clears on that edge unless a new last beat completes the same edge.
REQ-027 first && last on one beat SHALL produce out_data = that beat's tree sum.
REQ-028 Beats with neither flag and no prior first since reset SHALL accumulate onto acc reset value 0.
REQ-029 Beats with in_valid=0 SHALL propagate as bubbles and never alter acc.
REQ-030 Throughput SHALL be 1 beat/cycle while out_ready=1.

Reset
REQ-031 rst SHALL clear all valid tags, acc, sat flag, out_data=0, out_sat=0, out_valid=0; in_ready=1 in the cycle after reset.
REQ-032 rst mid-group SHALL discard partial accumulation and in-flight beats; no result emitted for that group.

Verification (LANES=4, DW=8)
REQ-033 ACCW=32: one beat first+last, all a=127, b=127 -> out_data=64516, out_sat=0, out_valid 4 edges after acceptance.
REQ-034 ACCW=32: three beats (first, mid, last), all a=-128, b=-128 -> single result 196608; a=-128, b=127 single beat -> -65024.
REQ-035 ACCW=18, SAT=1: two beats a=b=-128 (first, last) -> out_data=131071, out_sat=1; SAT=0 same stimulus -> out_data=-131072, out_sat=0.
REQ-036 out_ready=0 for 5 cycles with result pending, in_valid=1 -> in_ready=0, out_data stable, no beat lost; after out_ready=1, results emerge in order.
REQ-037 rst asserted after 2 beats of a 4-beat group -> out_valid=0, out_data=0; next single first+last beat of all 1s (a=b=1) -> out_data=4.
REQ-038 Back-to-back single-beat groups each cycle with out_ready=1 -> one result per cycle, no bubbles.
